// File: rtl/wave_meas.sv
// Waveform measurement: hysteretic rising mid-scale crossings give the span of NCYC periods,
// while min/max/peak-to-peak are tracked over the same sample window.
module wave_meas #(
  parameter int               DATA_W  = 14,
  parameter int               MID     = 8192,
  parameter int               HYST    = 64,
  parameter int               NCYC    = 4,
  parameter int               PER_W   = 24,
  parameter logic [PER_W-1:0] TIMEOUT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [PER_W-1:0]  period_sum,
  output logic [DATA_W-1:0] amp_max,
  output logic [DATA_W-1:0] amp_min,
  output logic [DATA_W-1:0] amp_pp
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_MEAS, S_DONE} state_t;

  localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);

  state_t            state, state_nxt;
  logic [PER_W-1:0]  cnt, wdog;
  logic [7:0]        ncr;
  logic              armed;
  logic [DATA_W-1:0] cur_max, cur_min;
  logic              below, above, counting, sample, wdog_hit, last_cross;

  assign below      = adc_data < LO_TH;
  assign above      = adc_data >= HI_TH;
  assign counting   = (state == S_ARM) || (state == S_SYNC) || (state == S_MEAS);
  assign sample     = en && adc_valid && counting;
  assign wdog_hit   = sample && (wdog == TIMEOUT - 1'b1);
  assign last_cross = (state == S_MEAS) && adc_valid && armed && above &&
                      (ncr == 8'(NCYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Disable and watchdog expiry both win over normal sequencing.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    if (!en || wdog_hit) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start)                state_nxt = S_ARM;
        S_ARM:   if (adc_valid && below)   state_nxt = S_SYNC;
        S_SYNC:  if (adc_valid && above)   state_nxt = S_MEAS;
        S_MEAS:  if (last_cross)           state_nxt = S_DONE;
        S_DONE:                            state_nxt = S_IDLE;
        default:                           state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      wdog       <= '0;
      ncr        <= '0;
      armed      <= 1'b0;
      cur_max    <= '0;
      cur_min    <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      period_sum <= '0;
      amp_max    <= '0;
      amp_min    <= '0;
      amp_pp     <= '0;
    end else begin
      done <= 1'b0;
      if (en && (state == S_IDLE) && start) begin
        timeout <= 1'b0;
        cnt     <= '0;
        wdog    <= '0;
        ncr     <= '0;
        armed   <= 1'b0;
      end
      if (sample)   wdog    <= wdog + 1'b1;
      if (wdog_hit) timeout <= 1'b1;
      // The first crossing opens the window; later ones close one period each.
      if (sample && !wdog_hit) begin
        if ((state == S_SYNC) && above) begin
          cnt     <= '0;
          cur_max <= adc_data;
          cur_min <= adc_data;
          armed   <= 1'b0;
        end else if (state == S_MEAS) begin
          if (cnt != '1)          cnt     <= cnt + 1'b1;
          if (adc_data > cur_max) cur_max <= adc_data;
          if (adc_data < cur_min) cur_min <= adc_data;
          if (below) begin
            armed <= 1'b1;
          end else if (armed && above) begin
            armed <= 1'b0;
            ncr   <= ncr + 8'd1;
          end
        end
      end
      if (en && (state == S_DONE)) begin
        done       <= 1'b1;
        period_sum <= cnt;
        amp_max    <= cur_max;
        amp_min    <= cur_min;
        amp_pp     <= cur_max - cur_min;
      end
    end
  end

endmodule

// File: tb/tb_wave_meas.sv
// Bench for wave_meas: sawtooth streams scored against an array-based crossing model.
module tb_wave_meas;
  localparam int NCYC = 4;
  localparam int LO   = 8128;
  localparam int HI   = 8256;

  logic        clk = 1'b0;
  logic        rst, en, start, adc_valid;
  logic [13:0] adc_data;
  logic        busy, done, timeout;
  logic [23:0] period_sum;
  logic [13:0] amp_max, amp_min, amp_pp;
  logic        to_busy, to_done, to_timeout;
  logic [23:0] to_period_sum;
  logic [13:0] to_amp_max, to_amp_min, to_amp_pp;

  int checks = 0;
  int failures = 0;
  int samp[$];
  bit m_found;
  int m_last, m_sum, m_max, m_min;
  int r_done_cnt, r_done_at, r_last_edge;
  int base_done_at;

  always #5 clk = ~clk;

  wave_meas dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .busy(busy), .done(done), .timeout(timeout), .period_sum(period_sum),
    .amp_max(amp_max), .amp_min(amp_min), .amp_pp(amp_pp));

  wave_meas #(.TIMEOUT(24'd1000)) dut_to (
    .clk(clk), .rst(rst), .en(en), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .busy(to_busy), .done(to_done), .timeout(to_timeout), .period_sum(to_period_sum),
    .amp_max(to_amp_max), .amp_min(to_amp_min), .amp_pp(to_amp_pp));

  // Sawtooth lo + ((i+ph) mod P)*step, optional +/-40 noise near mid-scale.
  task automatic gen_saw(input int lo, input int step, input int p, input int ph,
                         input int nper, input bit noise);
    int v;
    samp.delete();
    for (int i = 0; i < p * nper; i++) begin
      v = lo + ((i + ph) % p) * step;
      if (noise && v > 7800 && v < 8600) v = v + int'($urandom_range(80, 0)) - 40;
      if (v < 0) v = 0;
      if (v > 16383) v = 16383;
      samp.push_back(v);
    end
  endtask

  // Reference: scan the valid-sample stream for arm, first crossing, then NCYC more crossings.
  task automatic model(input int tmo);
    int n, i, c0, k;
    bit armed;
    n = samp.size();
    m_found = 0; m_last = -1; m_sum = 0; m_max = 0; m_min = 0;
    i = 0;
    while (i < n && samp[i] >= LO) i++;
    i++;
    while (i < n && samp[i] < HI) i++;
    if (i >= n) return;
    c0 = i; armed = 0; k = 0;
    for (int j = c0 + 1; j < n && k < NCYC; j++) begin
      if (samp[j] < LO) armed = 1;
      else if (armed && samp[j] >= HI) begin
        armed = 0; k++;
        if (k == NCYC) m_last = j;
      end
    end
    if (m_last < 0) return;
    if (m_last + 1 >= tmo) begin m_last = -1; return; end
    m_found = 1;
    m_sum = m_last - c0;
    m_max = samp[c0];
    m_min = samp[c0];
    for (int j = c0; j <= m_last; j++) begin
      if (samp[j] > m_max) m_max = samp[j];
      if (samp[j] < m_min) m_min = samp[j];
    end
  endtask

  task automatic kick();
    adc_valid = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Feeds samp one valid sample every vper cycles; records done pulses of the chosen instance.
  task automatic drive_run(input int vper, input int start_at, input bit use_to);
    int k = 0;
    int c = 0;
    int tail = 0;
    r_done_cnt = 0; r_done_at = -1; r_last_edge = -1;
    while (k < samp.size() || tail < 4) begin
      if (k < samp.size()) begin
        if (c % vper == 0) begin
          adc_valid = 1; adc_data = 14'(samp[k]);
          if (k == m_last) r_last_edge = c;
          k++;
        end else adc_valid = 0;
      end else begin
        adc_valid = 0; tail++;
      end
      start = (c == start_at);
      @(posedge clk); #1;
      if (use_to ? to_done : done) begin
        r_done_cnt++;
        if (r_done_at < 0) r_done_at = c;
      end
      c++;
    end
    adc_valid = 0; start = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; start = 0; adc_valid = 0; adc_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %0b expected 0", timeout); end
    checks++; if (period_sum !== 24'd0) begin failures++; $display("[TB] FAIL reset_period: got %0d expected 0", period_sum); end
    checks++; if (amp_max !== 14'd0 || amp_min !== 14'd0 || amp_pp !== 14'd0) begin
      failures++; $display("[TB] FAIL reset_amp: got %0d/%0d/%0d expected 0/0/0", amp_max, amp_min, amp_pp); end
  endtask

  task automatic test_ramp();
    gen_saw(0, 32, 512, 0, 5, 0);
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    base_done_at = r_done_at;
    checks++; if (r_done_cnt != 1) begin failures++; $display("[TB] FAIL ramp_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (r_done_at != r_last_edge + 1) begin failures++; $display("[TB] FAIL ramp_latency: got %0d expected %0d", r_done_at, r_last_edge + 1); end
    checks++; if (period_sum !== 24'd2048) begin failures++; $display("[TB] FAIL ramp_period: got %0d expected 2048", period_sum); end
    checks++; if (amp_max !== 14'd16352) begin failures++; $display("[TB] FAIL ramp_max: got %0d expected 16352", amp_max); end
    checks++; if (amp_min !== 14'd0) begin failures++; $display("[TB] FAIL ramp_min: got %0d expected 0", amp_min); end
    checks++; if (amp_pp !== 14'd16352) begin failures++; $display("[TB] FAIL ramp_pp: got %0d expected 16352", amp_pp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ramp_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_half_ramp();
    gen_saw(4096, 16, 512, 0, 5, 0);
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    checks++; if (r_done_cnt != 1) begin failures++; $display("[TB] FAIL half_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (period_sum !== 24'd2048) begin failures++; $display("[TB] FAIL half_period: got %0d expected 2048", period_sum); end
    checks++; if (amp_max !== 14'd12272 || amp_min !== 14'd4096) begin
      failures++; $display("[TB] FAIL half_minmax: got %0d/%0d expected 12272/4096", amp_max, amp_min); end
    checks++; if (amp_pp !== 14'd8176) begin failures++; $display("[TB] FAIL half_pp: got %0d expected 8176", amp_pp); end
  endtask

  task automatic test_sparse_valid();
    gen_saw(0, 32, 512, 0, 5, 0);
    model(32'hFFFFFF);
    kick();
    drive_run(3, -1, 0);
    checks++; if (r_done_cnt != 1) begin failures++; $display("[TB] FAIL sparse_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (r_done_at != r_last_edge + 1) begin failures++; $display("[TB] FAIL sparse_latency: got %0d expected %0d", r_done_at, r_last_edge + 1); end
    checks++; if (r_done_at * 2 < base_done_at * 5 || r_done_at * 2 > base_done_at * 7) begin
      failures++; $display("[TB] FAIL sparse_slowdown: got %0d cycles expected about 3x %0d", r_done_at, base_done_at); end
    checks++; if (period_sum !== 24'd2048 || amp_pp !== 14'd16352) begin
      failures++; $display("[TB] FAIL sparse_results: got %0d/%0d expected 2048/16352", period_sum, amp_pp); end
  endtask

  task automatic test_noise();
    gen_saw(0, 32, 512, 0, 5, 1);
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    checks++; if (r_done_cnt != 1) begin failures++; $display("[TB] FAIL noise_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (period_sum !== 24'(m_sum)) begin failures++; $display("[TB] FAIL noise_period: got %0d expected %0d", period_sum, m_sum); end
    checks++; if (amp_pp !== 14'(m_max - m_min)) begin failures++; $display("[TB] FAIL noise_pp: got %0d expected %0d", amp_pp, m_max - m_min); end
  endtask

  task automatic test_start_ignored();
    gen_saw(4096, 16, 512, 100, 5, 0);
    model(32'hFFFFFF);
    kick();
    drive_run(1, 1200, 0);
    checks++; if (r_done_cnt != 1) begin failures++; $display("[TB] FAIL restart_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (period_sum !== 24'(m_sum)) begin failures++; $display("[TB] FAIL restart_period: got %0d expected %0d", period_sum, m_sum); end
    checks++; if (amp_max !== 14'(m_max) || amp_min !== 14'(m_min)) begin
      failures++; $display("[TB] FAIL restart_minmax: got %0d/%0d expected %0d/%0d", amp_max, amp_min, m_max, m_min); end
  endtask

  task automatic test_rst_mid();
    gen_saw(0, 32, 512, 0, 2, 0);
    samp = samp[0:799];
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    checks++; if (r_done_cnt != 0 || busy !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_running: got done=%0d busy=%0b expected 0/1", r_done_cnt, busy); end
    rst = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_mid_flags: got %0b%0b%0b expected 000", busy, done, timeout); end
    checks++; if (period_sum !== 24'd0 || amp_max !== 14'd0 || amp_min !== 14'd0 || amp_pp !== 14'd0) begin
      failures++; $display("[TB] FAIL rst_mid_results: got %0d/%0d/%0d/%0d expected zeros", period_sum, amp_max, amp_min, amp_pp); end
    rst = 0;
    gen_saw(0, 32, 512, 0, 5, 0);
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    checks++; if (r_done_cnt != 1 || period_sum !== 24'd2048) begin
      failures++; $display("[TB] FAIL rst_mid_rerun: got done=%0d period=%0d expected 1/2048", r_done_cnt, period_sum); end
  endtask

  task automatic test_en_abort();
    gen_saw(0, 32, 512, 0, 2, 0);
    samp = samp[0:799];
    model(32'hFFFFFF);
    kick();
    drive_run(1, -1, 0);
    en = 0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL en_abort_busy: got %0b expected 0", busy); end
    checks++; if (period_sum !== 24'd2048 || amp_pp !== 14'd16352) begin
      failures++; $display("[TB] FAIL en_abort_kept: got %0d/%0d expected 2048/16352", period_sum, amp_pp); end
    en = 1;
  endtask

  task automatic test_random();
    int lo, hi, p, vper;
    for (int t = 0; t < 6; t++) begin
      p    = int'($urandom_range(200, 40));
      lo   = int'($urandom_range(6000, 0));
      hi   = int'($urandom_range(16383, 10500));
      vper = int'($urandom_range(3, 1));
      gen_saw(lo, (hi - lo) / (p - 1), p, int'($urandom_range(p - 1, 0)), NCYC + 2, 1'($urandom_range(1, 0)));
      model(32'hFFFFFF);
      kick();
      drive_run(vper, -1, 0);
      checks++; if (r_done_cnt != int'(m_found)) begin
        failures++; $display("[TB] FAIL rand%0d_done_count: got %0d expected %0d", t, r_done_cnt, m_found); end
      if (m_found) begin
        checks++; if (r_done_at != r_last_edge + 1) begin
          failures++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", t, r_done_at, r_last_edge + 1); end
        checks++; if (period_sum !== 24'(m_sum)) begin
          failures++; $display("[TB] FAIL rand%0d_period: got %0d expected %0d", t, period_sum, m_sum); end
        checks++; if (amp_max !== 14'(m_max) || amp_min !== 14'(m_min) || amp_pp !== 14'(m_max - m_min)) begin
          failures++; $display("[TB] FAIL rand%0d_amp: got %0d/%0d/%0d expected %0d/%0d/%0d", t,
                               amp_max, amp_min, amp_pp, m_max, m_min, m_max - m_min); end
      end
    end
  endtask

  task automatic test_timeout();
    int t_sum, t_max, t_min;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    gen_saw(0, 128, 128, 0, 5, 0);
    model(1000);
    kick();
    drive_run(1, -1, 1);
    t_sum = m_sum; t_max = m_max; t_min = m_min;
    checks++; if (r_done_cnt != 1 || to_period_sum !== 24'(t_sum)) begin
      failures++; $display("[TB] FAIL to_prerun: got done=%0d period=%0d expected 1/%0d", r_done_cnt, to_period_sum, t_sum); end
    samp.delete();
    for (int i = 0; i < 999; i++) samp.push_back(8192);
    model(1000);
    kick();
    drive_run(1, -1, 1);
    checks++; if (to_timeout !== 1'b0 || to_busy !== 1'b1) begin
      failures++; $display("[TB] FAIL to_before_limit: got timeout=%0b busy=%0b expected 0/1", to_timeout, to_busy); end
    samp.delete();
    samp.push_back(8192);
    drive_run(1, -1, 1);
    checks++; if (to_timeout !== 1'b1 || to_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL to_at_limit: got timeout=%0b busy=%0b expected 1/0", to_timeout, to_busy); end
    checks++; if (r_done_cnt != 0) begin failures++; $display("[TB] FAIL to_no_done: got %0d expected 0", r_done_cnt); end
    checks++; if (to_period_sum !== 24'(t_sum) || to_amp_max !== 14'(t_max) || to_amp_min !== 14'(t_min) ||
                  to_amp_pp !== 14'(t_max - t_min)) begin
      failures++; $display("[TB] FAIL to_results_kept: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                           to_period_sum, to_amp_max, to_amp_min, to_amp_pp, t_sum, t_max, t_min, t_max - t_min); end
    en = 0;
    @(posedge clk); #1;
    en = 1;
    checks++; if (to_timeout !== 1'b1) begin failures++; $display("[TB] FAIL to_en_keeps: got %0b expected 1", to_timeout); end
    kick();
    checks++; if (to_timeout !== 1'b0 || to_busy !== 1'b1) begin
      failures++; $display("[TB] FAIL to_cleared_by_start: got timeout=%0b busy=%0b expected 0/1", to_timeout, to_busy); end
    en = 0;
    @(posedge clk); #1;
    en = 1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_half_ramp();
    test_sparse_valid();
    test_noise();
    test_start_ignored();
    test_rst_mid();
    test_en_abort();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
